// File: rtl/alu_src_b_pipe.sv
// ALU operand-B source select with built-in sign-extend/shift; result registered, one cycle latency.
// Valid/ready output with a 2-entry skid buffer; in_ready drops only while the skid entry is occupied.
module alu_src_b_pipe #(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 16,
  parameter int SHIFT     = 2,
  parameter int INC_CONST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] b_data,
  input  logic [IMM_W-1:0] imm,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           new_entry;
  entry_t           main_q;
  entry_t           skid_q;
  logic             main_vld;
  logic             skid_vld;
  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] imm_sh;
  logic             accept;
  logic             handshake;
  logic             sel_illegal;

  assign imm_sx      = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_sh      = imm_sx << SHIFT;
  assign sel_illegal = sel[2] & sel[1];

  always_comb begin
    new_entry = '0;
    case (sel)
      3'b000:  new_entry.data = b_data;
      3'b001:  new_entry.data = WIDTH'(INC_CONST);
      3'b010:  new_entry.data = imm_sx;
      3'b011:  new_entry.data = WIDTH'(1);
      3'b100:  new_entry.data = imm_sh;
      3'b101:  new_entry.data = '0;
      default: new_entry.err  = 1'b1;
    endcase
  end

  assign in_ready    = !skid_vld;
  assign accept      = in_valid && in_ready;
  assign handshake   = main_vld && out_ready;
  assign out_valid   = main_vld;
  assign out_data    = main_q.data;
  assign out_sel_err = main_q.err;

  // Skid drain has priority; accept cannot coincide with it since in_ready is low then.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (handshake && skid_vld) begin
      main_q   <= skid_q;
      skid_vld <= 1'b0;
    end else if (accept && (!main_vld || out_ready)) begin
      main_q   <= new_entry;
      main_vld <= 1'b1;
    end else if (accept) begin
      skid_q   <= new_entry;
      skid_vld <= 1'b1;
    end else if (handshake) begin
      main_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (accept && sel_illegal && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_src_b_pipe.sv
// Bench for alu_src_b_pipe: directed scenarios plus randomized traffic against a queue-based reference.
module tb_alu_src_b_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] b_data = '0;
  logic [15:0] imm = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sel_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          model_err = 0;

  always #5 clock = ~clock;

  alu_src_b_pipe dut (
    .clock(clock), .reset_n(reset_n), .sel(sel), .b_data(b_data), .imm(imm),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count)
  );

  // Reference result: {error flag, operand} from the select rules, using plain integer arithmetic.
  function automatic logic [32:0] ref_entry(input logic [2:0] s, input logic [31:0] b, input logic [15:0] im);
    int          sx;
    logic [31:0] d;
    sx = (im >= 16'h8000) ? (int'(im) - 65536) : int'(im);
    case (s)
      3'd0: d = b;
      3'd1: d = 32'd4;
      3'd2: d = sx;
      3'd3: d = 32'd1;
      3'd4: d = sx * 4;
      3'd5: d = 32'd0;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, d};
  endfunction

  // Records accepted beats (as expected results) and delivered beats, mid-cycle while signals are stable.
  always @(negedge clock) begin
    if (!reset_n) begin
      model_err = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_entry(sel, b_data, imm));
        if (sel >= 3'd6 && model_err < 255) model_err = model_err + 1;
      end
      if (out_valid && out_ready) got_q.push_back({out_sel_err, out_data});
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) next_cycle();
    reset_n = 1'b1;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", out_sel_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_first_beat();
    sel = 3'b000; b_data = 32'h1234_5678; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h1234_5678) begin errors++; $display("FAIL first_data got %h want 12345678", out_data); end
    checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL first_sel_err got %b want 0", out_sel_err); end
  endtask

  task automatic test_immediates();
    logic [2:0]  s_t[6] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b011, 3'b101};
    logic [15:0] i_t[6] = '{16'hFFFC, 16'h0003, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    logic [31:0] e_t[6] = '{32'hFFFF_FFFC, 32'h0000_000C, 32'hFFFE_0000, 32'h4, 32'h1, 32'h0};
    out_ready = 1'b1;
    b_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      sel = s_t[i]; imm = i_t[i]; in_valid = 1'b1;
      next_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e_t[i] || out_sel_err !== 1'b0) begin
        errors++; $display("FAIL imm_%0d got v=%b d=%h e=%b want v=1 d=%h e=0", i, out_valid, out_data, out_sel_err, e_t[i]);
      end
    end
    in_valid = 1'b0;
    next_cycle();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    out_ready = 1'b0; sel = 3'b000;
    b_data = a; in_valid = 1'b1;
    next_cycle();
    checks++; if (in_ready !== 1'b1 || out_data !== a) begin errors++; $display("FAIL bp_a_main got rdy=%b d=%h want rdy=1 d=%h", in_ready, out_data, a); end
    b_data = b;
    next_cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_full got in_ready=%b want 0", in_ready); end
    b_data = c;
    next_cycle();
    checks++; if (in_ready !== 1'b0 || out_data !== a) begin errors++; $display("FAIL bp_stall got rdy=%b d=%h want rdy=0 d=%h", in_ready, out_data, a); end
    out_ready = 1'b1;
    next_cycle();
    checks++; if (out_data !== b || in_ready !== 1'b1) begin errors++; $display("FAIL bp_out_b got d=%h rdy=%b want d=%h rdy=1", out_data, in_ready, b); end
    next_cycle();
    in_valid = 1'b0;
    checks++; if (out_data !== c || out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_c got d=%h v=%b want d=%h v=1", out_data, out_valid, c); end
    next_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b want 0", out_valid); end
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    bit          acc;
    bit          stall;
    logic [32:0] held;
    int          n;
    acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel = 3'($urandom_range(0, 7));
        b_data = $urandom;
        imm = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid && in_ready;
      stall = out_valid && !out_ready;
      held = {out_sel_err, out_data};
      next_cycle();
      if (stall) begin
        checks++;
        if ({out_sel_err, out_data} !== held) begin errors++; $display("FAIL rnd_hold cyc %0d got %h want %h", i, {out_sel_err, out_data}, held); end
      end
      checks++;
      if (err_count !== 8'(model_err)) begin errors++; $display("FAIL rnd_err_count cyc %0d got %0d want %0d", i, err_count, model_err); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) next_cycle();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_beats got %0d want %0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd_beat_%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_illegal();
    apply_reset();
    sel = 3'b110; imm = 16'h1234; b_data = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    checks++; if (out_data !== 32'd0 || out_sel_err !== 1'b1) begin errors++; $display("FAIL ill_beat got d=%h e=%b want d=0 e=1", out_data, out_sel_err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ill_count1 got %0d want 1", err_count); end
    sel = 3'b111;
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      if (i == 99) begin
        checks++; if (err_count !== 8'd101) begin errors++; $display("FAIL ill_count101 got %0d want 101", err_count); end
      end
    end
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL ill_saturate got %0d want 255", err_count); end
    next_cycle();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL ill_hold got %0d want 255", err_count); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0; sel = 3'b000; in_valid = 1'b1;
    b_data = $urandom;
    next_cycle();
    b_data = $urandom;
    next_cycle();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin errors++; $display("FAIL rst_async_out got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_rdy got %b want 1", in_ready); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_async_cnt got %0d want 0", err_count); end
    @(posedge clock);
    #3 reset_n = 1'b1;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_%0d got v=%b want 0", i, out_valid); end
    end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rst_no_beats got %0d want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_immediates();
    test_back_to_back();
    test_random();
    test_illegal();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
